simon_playback_sequencer: RTL and testbench



---
 rtl/simon_pkg.sv | 27 ++
 rtl/simon_dwell_timer.sv | 27 ++
 rtl/simon_playback_sequencer.sv | 111 +++++++++++
 tb/tb_simon_playback_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared Simon game constants: playback FSM encoding, default dwell times, LED modes.
// Pure definitions; no logic, no timing.
package simon_pkg;

    localparam logic [2:0] PB_IDLE_ENC   = 3'd0;
    localparam logic [2:0] PB_FETCH_ENC  = 3'd1;
    localparam logic [2:0] PB_SHOW_ENC   = 3'd2;
    localparam logic [2:0] PB_GAP_ENC    = 3'd3;
    localparam logic [2:0] PB_FINISH_ENC = 3'd4;

    typedef enum logic [2:0] {
        PB_IDLE   = PB_IDLE_ENC,
        PB_FETCH  = PB_FETCH_ENC,
        PB_SHOW   = PB_SHOW_ENC,
        PB_GAP    = PB_GAP_ENC,
        PB_FINISH = PB_FINISH_ENC
    } pb_state_t;

    localparam int DEF_ON_CYCLES  = 4;
    localparam int DEF_GAP_CYCLES = 2;

    localparam logic [1:0] LED_MODE_OFF      = 2'd0;
    localparam logic [1:0] LED_MODE_PLAYBACK = 2'd1;
    localparam logic [1:0] LED_MODE_ECHO     = 2'd2;
    localparam logic [1:0] LED_MODE_FAIL     = 2'd3;

endpackage

// File: rtl/simon_dwell_timer.sv
// Loadable down-counter that stops at zero; zero flag is decoded from the count register.
// Load takes effect on the next edge; no backpressure.
module simon_dwell_timer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] value,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - CNT_WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/simon_playback_sequencer.sv
// Plays pattern memory entries 0..len-1 on the LEDs, each for ON_CYCLES then blank for GAP_CYCLES.
// Per entry 1+ON_CYCLES+GAP_CYCLES cycles, done one cycle after the last; no backpressure, start ignored while busy.
module simon_playback_sequencer
    import simon_pkg::*;
#(
    parameter int IDX_WIDTH  = 6,
    parameter int PAT_WIDTH  = 4,
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IDX_WIDTH:0]   seq_len,
    input  logic                 abort,
    output logic [IDX_WIDTH-1:0] mem_addr,
    input  logic [PAT_WIDTH-1:0] mem_rdata,
    output logic [PAT_WIDTH-1:0] pattern_leds,
    output logic                 busy,
    output logic                 done
);

    localparam int                   LEN_WIDTH = IDX_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN   = LEN_WIDTH'(1) << IDX_WIDTH;
    localparam logic [CNT_WIDTH-1:0] ON_LOAD   = CNT_WIDTH'(ON_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LOAD  = CNT_WIDTH'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit                   HAS_GAP   = (GAP_CYCLES > 0);

    pb_state_t            state;
    logic [IDX_WIDTH-1:0] idx;
    logic [LEN_WIDTH-1:0] len;
    logic                 tmr_load;
    logic [CNT_WIDTH-1:0] tmr_value;
    logic                 tmr_zero;
    logic                 last_elem;
    logic                 elem_end;

    simon_dwell_timer #(.CNT_WIDTH(CNT_WIDTH)) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    assign last_elem = ({1'b0, idx} == len - LEN_WIDTH'(1));
    assign elem_end  = tmr_zero && ((state == PB_GAP) || ((state == PB_SHOW) && !HAS_GAP));
    assign tmr_load  = (state == PB_FETCH) || ((state == PB_SHOW) && tmr_zero && HAS_GAP);
    assign tmr_value = (state == PB_FETCH) ? ON_LOAD : GAP_LOAD;

    // The memory has one cycle of latency, so the next address is presented in the
    // last cycle of the current element; its data is then ready at the end of FETCH.
    assign mem_addr = (elem_end && !last_elem) ? idx + IDX_WIDTH'(1) : idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= PB_IDLE;
            idx          <= '0;
            len          <= '0;
            pattern_leds <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state != PB_IDLE)) begin
                state        <= PB_IDLE;
                idx          <= '0;
                pattern_leds <= '0;
                busy         <= 1'b0;
            end else begin
                case (state)
                    PB_IDLE: if (start) begin
                        len  <= (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
                        idx  <= '0;
                        busy <= 1'b1;
                        if (seq_len == '0) begin
                            state <= PB_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= PB_FETCH;
                        end
                    end
                    PB_FETCH: begin
                        state        <= PB_SHOW;
                        pattern_leds <= mem_rdata;
                    end
                    PB_SHOW, PB_GAP: if (tmr_zero) begin
                        pattern_leds <= '0;
                        if (!elem_end) begin
                            state <= PB_GAP;
                        end else if (last_elem) begin
                            state <= PB_FINISH;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + IDX_WIDTH'(1);
                            state <= PB_FETCH;
                        end
                    end
                    PB_FINISH: begin
                        state <= PB_IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end
                    default: state <= PB_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_simon_playback_sequencer.sv
// Directed bench for the playback sequencer: one instance with a 2-cycle gap, one with no gap.
// Cycle k of a scenario is the k-th falling edge after the rising edge that accepted start.
module tb_simon_playback_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [6:0] seq_len = '0;
    logic [5:0] mem_addr;
    logic [3:0] mem_rdata;
    logic [3:0] pattern_leds;
    logic       busy;
    logic       done;

    logic       start_b = 1'b0;
    logic       abort_b = 1'b0;
    logic [6:0] seq_len_b = '0;
    logic [5:0] mem_addr_b;
    logic [3:0] mem_rdata_b;
    logic [3:0] pattern_leds_b;
    logic       busy_b;
    logic       done_b;

    logic [3:0] mem_a [64];
    logic [3:0] mem_b [64];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata   <= mem_a[mem_addr];
        mem_rdata_b <= mem_b[mem_addr_b];
    end

    simon_playback_sequencer #(
        .IDX_WIDTH(6), .PAT_WIDTH(4), .ON_CYCLES(4), .GAP_CYCLES(2), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seq_len(seq_len), .abort(abort),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .pattern_leds(pattern_leds),
        .busy(busy), .done(done)
    );

    simon_playback_sequencer #(
        .IDX_WIDTH(6), .PAT_WIDTH(4), .ON_CYCLES(4), .GAP_CYCLES(0), .CNT_WIDTH(16)
    ) dut_nogap (
        .clk(clk), .rst(rst), .start(start_b), .seq_len(seq_len_b), .abort(abort_b),
        .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b), .pattern_leds(pattern_leds_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic test_reset();
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 4'h0;
            mem_b[i] = 4'h0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({pattern_leds, busy, done, mem_addr} !== 12'h000) begin
            errors++;
            $display("FAIL reset_a: leds/busy/done/addr=%h want 000", {pattern_leds, busy, done, mem_addr});
        end
        checks++;
        if ({pattern_leds_b, busy_b, done_b, mem_addr_b} !== 12'h000) begin
            errors++;
            $display("FAIL reset_b: leds/busy/done/addr=%h want 000", {pattern_leds_b, busy_b, done_b, mem_addr_b});
        end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if ({pattern_leds, busy, done, mem_addr} !== 12'h000) begin
                errors++;
                $display("FAIL idle k=%0d: leds/busy/done/addr=%h want 000", k, {pattern_leds, busy, done, mem_addr});
            end
        end
    endtask

    task automatic test_three_entries();
        logic [3:0] exp_led;
        logic [5:0] exp_addr;
        mem_a[0] = 4'h3;
        mem_a[1] = 4'h5;
        mem_a[2] = 4'h9;
        seq_len = 7'd3;
        start = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            start = 1'b0;
            exp_led = (k >= 2 && k <= 5)   ? 4'h3 :
                      (k >= 9 && k <= 12)  ? 4'h5 :
                      (k >= 16 && k <= 19) ? 4'h9 : 4'h0;
            checks++;
            if (pattern_leds !== exp_led) begin
                errors++;
                $display("FAIL three_leds k=%0d: got %h want %h", k, pattern_leds, exp_led);
            end
            checks++;
            if (done !== (k == 22)) begin
                errors++;
                $display("FAIL three_done k=%0d: got %b want %b", k, done, (k == 22));
            end
            checks++;
            if (busy !== (k <= 22)) begin
                errors++;
                $display("FAIL three_busy k=%0d: got %b want %b", k, busy, (k <= 22));
            end
            if (k == 1 || k == 8 || k == 15 || k == 22 || k == 23) begin
                exp_addr = (k == 1) ? 6'd0 : (k == 8) ? 6'd1 : (k == 23) ? 6'd0 : 6'd2;
                checks++;
                if (mem_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL three_addr k=%0d: got %0d want %0d", k, mem_addr, exp_addr);
                end
            end
        end
    endtask

    task automatic test_zero_len();
        seq_len = 7'd0;
        start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({pattern_leds, busy, done} !== {4'h0, (k == 1), (k == 1)}) begin
                errors++;
                $display("FAIL zero_len k=%0d: leds/busy/done=%h_%b%b want %h_%b%b",
                         k, pattern_leds, busy, done, 4'h0, (k == 1), (k == 1));
            end
        end
    endtask

    task automatic test_no_gap();
        logic [3:0] exp_led;
        mem_b[0] = 4'hA;
        mem_b[1] = 4'hC;
        seq_len_b = 7'd2;
        start_b = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            start_b = 1'b0;
            exp_led = (k >= 2 && k <= 5) ? 4'hA : (k >= 7 && k <= 10) ? 4'hC : 4'h0;
            checks++;
            if (pattern_leds_b !== exp_led) begin
                errors++;
                $display("FAIL nogap_leds k=%0d: got %h want %h", k, pattern_leds_b, exp_led);
            end
            checks++;
            if ({busy_b, done_b} !== {(k <= 11), (k == 11)}) begin
                errors++;
                $display("FAIL nogap_busy_done k=%0d: got %b%b want %b%b", k, busy_b, done_b, (k <= 11), (k == 11));
            end
        end
    endtask

    task automatic test_abort();
        logic [3:0] exp_led;
        seq_len = 7'd3;
        start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            start = 1'b0;
            exp_led = (k >= 2 && k <= 5) ? 4'h3 : (k >= 9 && k <= 12) ? 4'h5 : 4'h0;
            checks++;
            if ({pattern_leds, done} !== {exp_led, 1'b0}) begin
                errors++;
                $display("FAIL abort_pre k=%0d: leds/done=%h_%b want %h_0", k, pattern_leds, done, exp_led);
            end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({pattern_leds, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL abort_stop: leds/busy/done=%h_%b%b want 0_00", pattern_leds, busy, done);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, mem_addr} !== 8'h00) begin
                errors++;
                $display("FAIL abort_quiet k=%0d: busy/done/addr=%b%b_%0d want 00_0", k, busy, done, mem_addr);
            end
        end
        seq_len = 7'd1;
        start = 1'b1;
        abort = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            exp_led = (k >= 2 && k <= 5) ? 4'h3 : 4'h0;
            checks++;
            if (pattern_leds !== exp_led) begin
                errors++;
                $display("FAIL replay_leds k=%0d: got %h want %h", k, pattern_leds, exp_led);
            end
            checks++;
            if ({busy, done} !== {(k <= 8), (k == 8)}) begin
                errors++;
                $display("FAIL replay_busy_done k=%0d: got %b%b want %b%b", k, busy, done, (k <= 8), (k == 8));
            end
        end
    endtask

    task automatic test_reset_mid_show();
        seq_len = 7'd3;
        start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (pattern_leds !== 4'h3) begin
            errors++;
            $display("FAIL rst_pre_show: got %h want 3", pattern_leds);
        end
        rst = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            checks++;
            if ({pattern_leds, busy, done} !== 6'b0) begin
                errors++;
                $display("FAIL rst_mid j=%0d: leds/busy/done=%h_%b%b want 0_00", j, pattern_leds, busy, done);
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({pattern_leds, busy, done, mem_addr} !== 12'h000) begin
            errors++;
            $display("FAIL rst_after: leds/busy/done/addr=%h want 000", {pattern_leds, busy, done, mem_addr});
        end
    endtask

    task automatic test_saturate_and_restart_ignored();
        int bad_led = 0;
        int bad_addr = 0;
        int done_cnt = 0;
        int done_k = -1;
        int el;
        int pos;
        logic [3:0] exp_led;
        for (int i = 0; i < 64; i++) mem_a[i] = 4'((i % 15) + 1);
        seq_len = 7'd69;
        start = 1'b1;
        for (int k = 1; k <= 460; k++) begin
            @(negedge clk);
            start = 1'b0;
            exp_led = 4'h0;
            if (k <= 448) begin
                pos = (k - 1) % 7;
                el  = (k - 1) / 7;
                if (pos >= 1 && pos <= 4) exp_led = mem_a[el];
                if (pos == 0 && mem_addr !== 6'(el)) bad_addr++;
            end
            if (pattern_leds !== exp_led) bad_led++;
            if (done === 1'b1) begin
                done_cnt++;
                done_k = k;
            end
            if (k == 449) begin
                checks++;
                if (mem_addr !== 6'd63) begin
                    errors++;
                    $display("FAIL sat_finish_addr: got %0d want 63", mem_addr);
                end
            end
            if (k % 40 == 3 && k < 440) begin
                start = 1'b1;
                seq_len = 7'd1;
            end
        end
        checks++;
        if (bad_led !== 0) begin
            errors++;
            $display("FAIL sat_leds: %0d wrong cycles, want 0", bad_led);
        end
        checks++;
        if (bad_addr !== 0) begin
            errors++;
            $display("FAIL sat_fetch_addr: %0d wrong fetches, want 0", bad_addr);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL sat_done_count: got %0d want 1", done_cnt);
        end
        checks++;
        if (done_k !== 449) begin
            errors++;
            $display("FAIL sat_done_cycle: got %0d want 449", done_k);
        end
        checks++;
        if ({busy, mem_addr} !== 7'h00) begin
            errors++;
            $display("FAIL sat_idle: busy/addr=%b_%0d want 0_0", busy, mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_three_entries();
        test_zero_len();
        test_no_gap();
        test_abort();
        test_reset_mid_show();
        test_saturate_and_restart_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
